// File: rtl/arm_core_pkg.sv
// Shared core definitions: architectural register geometry and the common
// word / register-index types used by the register file and its neighbours.
package arm_core_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int NUM_REGS   = 16;
    localparam int REG_IDX_W  = $clog2(NUM_REGS);

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : arm_core_pkg

// File: rtl/regfile_pending_ctr.sv
// One saturating up/down pending-write counter for a single architectural
// register. inc and dec in the same cycle cancel out. A dec at zero is ignored.
// An inc at the maximum value holds the count and raises sat_err for that cycle.
module regfile_pending_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              sat_err
);

    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [PEND_W-1:0] cnt_r;
    logic [PEND_W-1:0] cnt_next_s;
    logic              sat_err_s;

    // Next-count and saturation-error decode from the inc/dec pair.
    always_comb begin
        cnt_next_s = cnt_r;
        sat_err_s  = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r == CNT_MAX) begin
                    sat_err_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            2'b01: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Counter state; reset discards any in-flight writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign cnt     = cnt_r;
    assign sat_err = sat_err_s;

endmodule : regfile_pending_ctr

// File: rtl/wb_register_file.sv
// Architectural register file R0-R15 fed by the write-back stage, with two
// combinational read ports for ID, a per-register pending-write scoreboard and
// the RAW / structural stall request. Optional same-cycle write-to-read
// forwarding is enabled by defining WB_BYPASS_EN.
module wb_register_file
    import arm_core_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wb_en,
    input  reg_idx_t wb_dest,
    input  word_t    wb_value,
    input  reg_idx_t id_src1,
    input  reg_idx_t id_src2,
    input  logic     id_use_src2,
    input  logic     id_issue,
    input  logic     id_wb_en,
    input  reg_idx_t id_dest,
    output word_t    reg1,
    output word_t    reg2,
    output logic     hazard,
    output logic     pend_ovf
);

    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    word_t             regs_r [NUM_REGS];
    logic [PEND_W-1:0] cnt_s [NUM_REGS];
    logic [PEND_W-1:0] cnt_eff_s [NUM_REGS];
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] sat_s;
    logic              pend_ovf_r;
    word_t             reg1_s;
    word_t             reg2_s;
    logic              hazard_s;

    // Register array write port; reset clears every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {WORD_WIDTH{1'b0}};
            end
        end else if (wb_en) begin
            regs_r[wb_dest] <= wb_value;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        assign inc_s[g] = id_issue & id_wb_en & (id_dest == REG_IDX_W'(g));
        assign dec_s[g] = wb_en & (wb_dest == REG_IDX_W'(g));

        regfile_pending_ctr #(
            .PEND_W (PEND_W)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc_s[g]),
            .dec     (dec_s[g]),
            .cnt     (cnt_s[g]),
            .sat_err (sat_s[g])
        );
    end

    // Sticky overflow flag: any issue that hit a saturated counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_ovf_r <= 1'b0;
        end else if (|sat_s) begin
            pend_ovf_r <= 1'b1;
        end
    end

    // Effective pending counts seen by readers; a retiring write stops stalling when forwarded.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_eff_s[r] = cnt_s[r];
`ifdef WB_BYPASS_EN
            if (dec_s[r] && (cnt_s[r] != CNT_ZERO)) begin
                cnt_eff_s[r] = cnt_s[r] - CNT_ONE;
            end else begin
                cnt_eff_s[r] = cnt_s[r];
            end
`endif
        end
    end

    // Read muxes, optionally forwarding the value being written this cycle.
    always_comb begin
        reg1_s = regs_r[id_src1];
        reg2_s = regs_r[id_src2];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_dest == id_src1)) begin
            reg1_s = wb_value;
        end else begin
            reg1_s = regs_r[id_src1];
        end
        if (wb_en && (wb_dest == id_src2)) begin
            reg2_s = wb_value;
        end else begin
            reg2_s = regs_r[id_src2];
        end
`endif
    end

    // Stall on a pending source write, or on a destination counter that cannot take another issue.
    // id_issue is deliberately not an input here so ID can gate issue with ~hazard without a loop.
    always_comb begin
        hazard_s = (cnt_eff_s[id_src1] != CNT_ZERO)
                 | (id_use_src2 & (cnt_eff_s[id_src2] != CNT_ZERO))
                 | (id_wb_en & (cnt_s[id_dest] == CNT_MAX));
    end

    assign reg1     = reg1_s;
    assign reg2     = reg2_s;
    assign hazard   = hazard_s;
    assign pend_ovf = pend_ovf_r;

endmodule : wb_register_file

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed scenarios followed by
// random traffic, compared against an array/integer reference model.
module tb_wb_register_file;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_use_src2;
    logic        id_issue;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        hazard;
    logic        pend_ovf;

    int checks;
    int errors;

    // reference model state
    logic [31:0] regs_m [16];
    int          cnt_m [16];
    logic        ovf_m;
    localparam int PMAX = 3;

    wb_register_file dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use_src2 (id_use_src2),
        .id_issue    (id_issue),
        .id_wb_en    (id_wb_en),
        .id_dest     (id_dest),
        .reg1        (reg1),
        .reg2        (reg2),
        .hazard      (hazard),
        .pend_ovf    (pend_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            regs_m[i] = 32'h0;
            cnt_m[i]  = 0;
        end
        ovf_m = 1'b0;
    endtask

    function automatic int eff_cnt(input int r);
        int e;
        e = cnt_m[r];
`ifdef WB_BYPASS_EN
        if (wb_en && (int'(wb_dest) == r) && e > 0) e = e - 1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] idx);
`ifdef WB_BYPASS_EN
        if (wb_en && wb_dest == idx) return wb_value;
`endif
        return regs_m[idx];
    endfunction

    function automatic logic exp_hazard();
        return (eff_cnt(int'(id_src1)) != 0)
            || (id_use_src2 && eff_cnt(int'(id_src2)) != 0)
            || (id_wb_en && cnt_m[id_dest] == PMAX);
    endfunction

    task automatic model_clock();
        for (int r = 0; r < 16; r++) begin
            bit inc, dec;
            inc = id_issue && id_wb_en && (int'(id_dest) == r);
            dec = wb_en && (int'(wb_dest) == r);
            if (inc && !dec) begin
                if (cnt_m[r] == PMAX) ovf_m = 1'b1;
                else cnt_m[r] = cnt_m[r] + 1;
            end else if (dec && !inc) begin
                if (cnt_m[r] > 0) cnt_m[r] = cnt_m[r] - 1;
            end
        end
        if (wb_en) regs_m[wb_dest] = wb_value;
    endtask

    // Check outputs against the model for the current inputs, then clock once.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".reg1"}, reg1, exp_read(id_src1));
        check({tag, ".reg2"}, reg2, exp_read(id_src2));
        check({tag, ".hazard"}, {31'h0, hazard}, {31'h0, exp_hazard()});
        check({tag, ".pend_ovf"}, {31'h0, pend_ovf}, {31'h0, ovf_m});
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'h0;
        id_src1 = 4'd0; id_src2 = 4'd0; id_use_src2 = 1'b0;
        id_issue = 1'b0; id_wb_en = 1'b0; id_dest = 4'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.reg1", reg1, 32'h0);
        check("rst.hazard", {31'h0, hazard}, 32'h0);
        check("rst.pend_ovf", {31'h0, pend_ovf}, 32'h0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // write/read
        idle(); wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'hDEADBEEF;
        cycle("wr5");
        idle(); wb_dest = 4'd5; wb_value = 32'h12345678; id_src1 = 4'd5;
        #1 check("rd5", reg1, 32'hDEADBEEF);
        cycle("rd5m");
        idle(); id_src1 = 4'd5;
        #1 check("rd5_hold", reg1, 32'hDEADBEEF);
        cycle("rd5h");

        // RAW stall on R2
        idle(); id_issue = 1'b1; id_wb_en = 1'b1; id_dest = 4'd2;
        cycle("iss2");
        idle(); id_src1 = 4'd2;
        #1 check("raw2.stall", {31'h0, hazard}, 32'h1);
        cycle("raw2a");
        idle(); id_src1 = 4'd2; wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hCAFEF00D;
`ifdef WB_BYPASS_EN
        #1 check("raw2.wbcyc_hz", {31'h0, hazard}, 32'h0);
        check("raw2.fwd", reg1, 32'hCAFEF00D);
`else
        #1 check("raw2.wbcyc_hz", {31'h0, hazard}, 32'h1);
`endif
        cycle("raw2b");
        idle(); id_src1 = 4'd2;
        #1 check("raw2.after_hz", {31'h0, hazard}, 32'h0);
        check("raw2.after_val", reg1, 32'hCAFEF00D);
        cycle("raw2c");

        // simultaneous issue and WB on R7
        idle(); id_issue = 1'b1; id_wb_en = 1'b1; id_dest = 4'd7;
        cycle("iss7");
        idle(); id_issue = 1'b1; id_wb_en = 1'b1; id_dest = 4'd7;
        wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h00000077;
        cycle("sim7");
        idle(); id_src2 = 4'd7; id_use_src2 = 1'b1;
        #1 check("sim7.hz", {31'h0, hazard}, 32'h1);
        cycle("sim7b");
        idle(); id_src2 = 4'd7; id_use_src2 = 1'b0;
        #1 check("sim7.nouse", {31'h0, hazard}, 32'h0);
        cycle("sim7c");
        idle(); wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h00000777;
        cycle("wb7");

        // spurious WB to R4
        idle(); wb_en = 1'b1; wb_dest = 4'd4; wb_value = 32'h44444444;
        cycle("spur4");
        idle(); id_src1 = 4'd4; id_src2 = 4'd4; id_use_src2 = 1'b1;
        #1 check("spur4.val", reg1, 32'h44444444);
        check("spur4.hz", {31'h0, hazard}, 32'h0);
        check("spur4.ovf", {31'h0, pend_ovf}, 32'h0);
        cycle("spur4b");

        // mid-run reset with R3 pending
        idle(); id_issue = 1'b1; id_wb_en = 1'b1; id_dest = 4'd3;
        cycle("iss3");
        idle(); id_src1 = 4'd3;
        #1 check("pre_rst.hz", {31'h0, hazard}, 32'h1);
        rst = 1'b0;
        model_reset();
        #1 check("midrst.reg1", reg1, 32'h0);
        check("midrst.hz", {31'h0, hazard}, 32'h0);
        check("midrst.ovf", {31'h0, pend_ovf}, 32'h0);
        #1 rst = 1'b1;
        #1 check("postrst.r3", reg1, 32'h0);
        check("postrst.hz", {31'h0, hazard}, 32'h0);
        cycle("postrst");

        // saturation on R9
        for (int k = 0; k < 3; k++) begin
            idle(); id_issue = 1'b1; id_wb_en = 1'b1; id_dest = 4'd9;
            cycle("iss9");
        end
        idle(); id_wb_en = 1'b1; id_dest = 4'd9;
        #1 check("sat9.hz", {31'h0, hazard}, 32'h1);
        check("sat9.ovf0", {31'h0, pend_ovf}, 32'h0);
        id_issue = 1'b1;
        cycle("force9");
        idle(); id_src1 = 4'd9;
        #1 check("sat9.ovf1", {31'h0, pend_ovf}, 32'h1);
        cycle("sat9b");
        for (int k = 0; k < 3; k++) begin
            idle(); wb_en = 1'b1; wb_dest = 4'd9; wb_value = $urandom;
            cycle("drain9");
        end
        idle(); id_src1 = 4'd9;
        #1 check("sat9.drained", {31'h0, hazard}, 32'h0);
        cycle("sat9c");

        // random traffic, then reset and more random traffic
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 150; n++) begin
                wb_en       = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                wb_dest     = 4'($urandom_range(0, 15));
                wb_value    = $urandom;
                id_src1     = 4'($urandom_range(0, 15));
                id_src2     = 4'($urandom_range(0, 15));
                id_use_src2 = 1'($urandom_range(0, 1));
                id_wb_en    = 1'($urandom_range(0, 1));
                id_dest     = 4'($urandom_range(0, 15));
                id_issue    = 1'($urandom_range(0, 1));
                cycle("rand");
            end
            idle();
            rst = 1'b0;
            model_reset();
            #2 rst = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_register_file
